// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF    = 8;
   localparam int DATA_W_DEF    = 16;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with bounded bursts and alternating tie-break.
//
// state | meaning
// IDLE  | no owner; next grant picked from requests and last_owner
// OWN0  | requester 0 owns the memory port
// OWN1  | requester 1 owns the memory port
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_in,
   input  logic [DATA_W-1:0] mem_out
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_d;
   logic             last_owner, last_owner_d;
   logic             accept0, accept1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         burst_cnt  <= '0;
         last_owner <= 1'b1;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
      end else begin
         state_q    <= state_d;
         burst_cnt  <= burst_cnt_d;
         last_owner <= last_owner_d;
         rvalid0    <= accept0 & ~we0;
         rvalid1    <= accept1 & ~we1;
      end
   end

   always_comb begin
      state_d      = state_q;
      burst_cnt_d  = burst_cnt;
      last_owner_d = last_owner;
      case (state_q)
         IDLE: begin
            burst_cnt_d = '0;
            if (req0 && req1)
               state_d = last_owner ? OWN0 : OWN1;
            else if (req0)
               state_d = OWN0;
            else if (req1)
               state_d = OWN1;
         end
         OWN0: begin
            if (!req0) begin
               burst_cnt_d = '0;
               state_d     = req1 ? OWN1 : IDLE;
            end else if (burst_cnt != CNT_LAST) begin
               burst_cnt_d = burst_cnt + CNT_W'(1);
            end else begin
               // burst exhausted: hand over only if the other side is waiting
               burst_cnt_d = '0;
               if (req1)
                  state_d = OWN1;
            end
         end
         OWN1: begin
            if (!req1) begin
               burst_cnt_d = '0;
               state_d     = req0 ? OWN0 : IDLE;
            end else if (burst_cnt != CNT_LAST) begin
               burst_cnt_d = burst_cnt + CNT_W'(1);
            end else begin
               burst_cnt_d = '0;
               if (req0)
                  state_d = OWN0;
            end
         end
         default: begin
            state_d     = IDLE;
            burst_cnt_d = '0;
         end
      endcase
      if (state_d == OWN0)
         last_owner_d = 1'b0;
      else if (state_d == OWN1)
         last_owner_d = 1'b1;
   end

   always_comb begin
      gnt0     = (state_q == OWN0);
      gnt1     = (state_q == OWN1);
      // no transfer is accepted while reset is being sampled
      accept0  = rst_n & gnt0 & req0;
      accept1  = rst_n & gnt1 & req1;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_in   = '0;
      if (accept0) begin
         mem_we   = we0;
         mem_addr = addr0;
         mem_in   = wdata0;
      end else if (accept1) begin
         mem_we   = we1;
         mem_addr = addr1;
         mem_in   = wdata1;
      end
      rdata0 = rvalid0 ? mem_out : '0;
      rdata1 = rvalid1 ? mem_out : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 16;
   localparam int MAX_BURST = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req0, req1, we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1, rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_in;
   logic [DATA_W-1:0] mem_out;
   logic              preload;
   logic [DATA_W-1:0] mem_model [256];

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_BURST(MAX_BURST)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0),
      .req1    (req1),
      .we0     (we0),
      .we1     (we1),
      .addr0   (addr0),
      .addr1   (addr1),
      .wdata0  (wdata0),
      .wdata1  (wdata1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .rvalid0 (rvalid0),
      .rvalid1 (rvalid1),
      .rdata0  (rdata0),
      .rdata1  (rdata1),
      .mem_we  (mem_we),
      .mem_addr(mem_addr),
      .mem_in  (mem_in),
      .mem_out (mem_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (preload)
         mem_model[8'h10] <= 16'hBEEF;
      else if (mem_we)
         mem_model[mem_addr] <= mem_in;
      mem_out <= mem_model[mem_addr];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      logic eg0, eg1, ev0, ev1;
      idle_inputs();
      rst_n   = 1'b0;
      preload = 1'b1;
      mem_out = '0;
      next_cycle();
      next_cycle();
      preload = 1'b0;
      #1;
      check_val("rst_gnt0", 32'(gnt0), 0);
      check_val("rst_gnt1", 32'(gnt1), 0);
      check_val("rst_rvalid0", 32'(rvalid0), 0);
      check_val("rst_rvalid1", 32'(rvalid1), 0);
      check_val("rst_mem_we", 32'(mem_we), 0);

      // single read by requester 0
      rst_n = 1'b1;
      req0 = 1'b1; addr0 = 8'h10;
      #1;
      check_val("rd_t0_gnt0", 32'(gnt0), 0);
      next_cycle(); #1;
      check_val("rd_t1_gnt0", 32'(gnt0), 1);
      check_val("rd_t1_addr", 32'(mem_addr), 32'h10);
      check_val("rd_t1_we", 32'(mem_we), 0);
      check_val("rd_t1_rvalid0", 32'(rvalid0), 0);
      next_cycle();
      req0 = 1'b0;
      #1;
      check_val("rd_t2_rvalid0", 32'(rvalid0), 1);
      check_val("rd_t2_rdata0", 32'(rdata0), 32'hBEEF);
      next_cycle(); #1;
      check_val("rd_t3_rvalid0", 32'(rvalid0), 0);
      check_val("rd_t3_rdata0", 32'(rdata0), 0);
      check_val("rd_t3_gnt0", 32'(gnt0), 0);

      // single write by requester 1
      next_cycle();
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h22; wdata1 = 16'h1234;
      #1;
      check_val("wr_t0_gnt1", 32'(gnt1), 0);
      next_cycle(); #1;
      check_val("wr_t1_gnt1", 32'(gnt1), 1);
      check_val("wr_t1_gnt0", 32'(gnt0), 0);
      check_val("wr_t1_we", 32'(mem_we), 1);
      check_val("wr_t1_addr", 32'(mem_addr), 32'h22);
      check_val("wr_t1_din", 32'(mem_in), 32'h1234);
      next_cycle();
      idle_inputs();
      #1;
      check_val("wr_t2_rvalid1", 32'(rvalid1), 0);
      check_val("wr_t2_gnt1", 32'(gnt1), 1);
      check_val("wr_t2_we", 32'(mem_we), 0);
      next_cycle(); #1;
      check_val("wr_t3_rvalid1", 32'(rvalid1), 0);
      check_val("wr_t3_gnt1", 32'(gnt1), 0);

      // both requesters held from reset: 4-beat bursts alternating 0,1,0
      do_reset();
      req0 = 1'b1; addr0 = 8'h10;
      req1 = 1'b1; addr1 = 8'h22;
      for (int i = 0; i <= 12; i++) begin
         if (i > 0) next_cycle();
         #1;
         eg0 = (i >= 1 && i <= 4) || (i >= 9 && i <= 12);
         eg1 = (i >= 5 && i <= 8);
         ev0 = (i >= 2 && i <= 5) || (i >= 10 && i <= 12);
         ev1 = (i >= 6 && i <= 9);
         check_val($sformatf("tie_c%0d_gnt0", i), 32'(gnt0), 32'(eg0));
         check_val($sformatf("tie_c%0d_gnt1", i), 32'(gnt1), 32'(eg1));
         check_val($sformatf("tie_c%0d_both", i), 32'(gnt0 & gnt1), 0);
         check_val($sformatf("tie_c%0d_rvalid0", i), 32'(rvalid0), 32'(ev0));
         check_val($sformatf("tie_c%0d_rvalid1", i), 32'(rvalid1), 32'(ev1));
         check_val($sformatf("tie_c%0d_rv_both", i), 32'(rvalid0 & rvalid1), 0);
         check_val($sformatf("tie_c%0d_rdata0", i), 32'(rdata0), ev0 ? 32'hBEEF : 0);
         check_val($sformatf("tie_c%0d_rdata1", i), 32'(rdata1), ev1 ? 32'h1234 : 0);
      end
      next_cycle();
      idle_inputs();
      next_cycle();

      // requester 0 alone: grant must not gap across the burst wrap
      next_cycle();
      req0 = 1'b1; addr0 = 8'h10;
      for (int i = 0; i <= 10; i++) begin
         if (i > 0) next_cycle();
         #1;
         check_val($sformatf("solo_c%0d_gnt0", i), 32'(gnt0), (i >= 1) ? 1 : 0);
         check_val($sformatf("solo_c%0d_gnt1", i), 32'(gnt1), 0);
         check_val($sformatf("solo_c%0d_rvalid0", i), 32'(rvalid0), (i >= 2) ? 1 : 0);
      end
      next_cycle();
      idle_inputs();
      next_cycle();

      // reset on the second beat of a read burst
      next_cycle();
      req0 = 1'b1; addr0 = 8'h10;
      #1;
      check_val("mid_t0_gnt0", 32'(gnt0), 0);
      next_cycle(); #1;
      check_val("mid_t1_gnt0", 32'(gnt0), 1);
      next_cycle();
      rst_n = 1'b0;
      #1;
      check_val("mid_t2_gnt0", 32'(gnt0), 1);
      check_val("mid_t2_we", 32'(mem_we), 0);
      next_cycle();
      rst_n = 1'b1;
      req0 = 1'b1; req1 = 1'b1; addr1 = 8'h22;
      #1;
      check_val("mid_t3_gnt0", 32'(gnt0), 0);
      check_val("mid_t3_gnt1", 32'(gnt1), 0);
      check_val("mid_t3_rvalid0", 32'(rvalid0), 0);
      check_val("mid_t3_rdata0", 32'(rdata0), 0);
      check_val("mid_t3_we", 32'(mem_we), 0);
      next_cycle(); #1;
      check_val("mid_t4_gnt0", 32'(gnt0), 1);
      check_val("mid_t4_gnt1", 32'(gnt1), 0);

      idle_inputs();
      next_cycle();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
